lavadora_multiprograma: RTL and testbench

Parametrised coin-operated laundry controller, successor of the fixed three-program washer controller. It accumulates coin credit and, on payment completion, validates the credit against the cost of a user-selected program. It then emits a configurable pulse train on that program's activation line and returns excess credit as change pulses. It sits between the coin acceptor/panel buttons and the machine actuator drivers.

---
 rtl/lavadora_pkg.sv | 21 ++
 rtl/lavadora_multiprograma_generador_pulsos.sv | 33 +++
 rtl/lavadora_multiprograma.sv | 180 ++++++++++++++++++
 tb/tb_lavadora_multiprograma.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lavadora_pkg.sv
// Shared types and default configuration for the multi-program laundry controller.
package lavadora_pkg;

    localparam int unsigned NUM_PROG_DEF = 3;
    localparam int unsigned CNT_W_DEF    = 5;
    localparam int unsigned N_PULSOS_DEF = 2;
    localparam int unsigned TIMEOUT_DEF  = 64;

    // Program 0 = secado, 1 = lavado, 2 = lavado pesado
    localparam logic [NUM_PROG_DEF*CNT_W_DEF-1:0] COSTOS_DEF = {5'd9, 5'd4, 5'd3};

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PAGO,
        ST_PULSO_ON,
        ST_PULSO_OFF,
        ST_CAMBIO_ON,
        ST_CAMBIO_OFF
    } estado_t;

endpackage

// File: rtl/lavadora_multiprograma_generador_pulsos.sv
// Pulse-train generator: on load emits 'count' pulses of one high cycle followed by one low cycle.
module generador_pulsos #(
    parameter int unsigned W = 5
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] count,
    output logic         pulse,
    output logic         done_c
);

    logic [W-1:0] rem;

    // rem counts pulses still owed after the one currently high; count is never 0 on load
    always_ff @(posedge clk) begin
        if (reset) begin
            pulse <= 1'b0;
            rem   <= '0;
        end else if (load) begin
            pulse <= 1'b1;
            rem   <= count - W'(1);
        end else if (pulse) begin
            pulse <= 1'b0;
        end else if (rem != '0) begin
            pulse <= 1'b1;
            rem   <= rem - W'(1);
        end
    end

    assign done_c = !pulse && (rem == '0);

endmodule

// File: rtl/lavadora_multiprograma.sv
// Coin-operated washer controller: credit accumulation, program validation, activation and change pulse trains.
module lavadora_multiprograma
    import lavadora_pkg::*;
#(
    parameter int unsigned                 NUM_PROG = NUM_PROG_DEF,
    parameter int unsigned                 CNT_W    = CNT_W_DEF,
    parameter logic [NUM_PROG*CNT_W-1:0]   COSTOS   = COSTOS_DEF,
    parameter int unsigned                 N_PULSOS = N_PULSOS_DEF,
    parameter int unsigned                 TIMEOUT  = TIMEOUT_DEF,
    parameter int unsigned                 PSEL_W   = (NUM_PROG > 1) ? $clog2(NUM_PROG) : 1
) (
    input  logic                clk,
    input  logic                RESET,
    input  logic                INTRO_MONEDA,
    input  logic                FINALIZAR_PAGO,
    input  logic [PSEL_W-1:0]   PROGRAMA_SEL,
    output logic [NUM_PROG-1:0] ACTIVAR,
    output logic                INSUFICIENTE,
    output logic                CAMBIO,
    output logic                OCUPADO,
    output logic [CNT_W-1:0]    CREDITO
);

    localparam int unsigned NP_W      = $clog2(N_PULSOS + 1);
    localparam int unsigned GEN_W     = (NP_W > CNT_W) ? NP_W : CNT_W;
    localparam int unsigned TO_W      = $clog2(TIMEOUT);
    localparam int unsigned SEL_EXT_W = PSEL_W + 1;

    estado_t             state, state_n;
    logic                moneda_prev;
    logic [CNT_W-1:0]    credito_q, credito_n;
    logic [CNT_W-1:0]    cambio_q, cambio_n;
    logic [TO_W-1:0]     to_q, to_n;
    logic [NUM_PROG-1:0] oh_q, oh_n;
    logic                cmode_q, cmode_n;
    logic                insuf_q, insuf_n;
    logic                ocup_q, ocup_n;

    logic                coin_edge;
    logic                sel_invalid;
    logic [CNT_W-1:0]    costo;
    logic [CNT_W-1:0]    credito_inc;
    logic                gen_load, gen_pulse, gen_done;
    logic [GEN_W-1:0]    gen_count;

    assign coin_edge   = INTRO_MONEDA && !moneda_prev;
    assign sel_invalid = {1'b0, PROGRAMA_SEL} >= SEL_EXT_W'(NUM_PROG);
    assign credito_inc = (credito_q == {CNT_W{1'b1}}) ? credito_q : credito_q + CNT_W'(1);

    // Cost lookup guarded so an out-of-range select never indexes past the vector
    always_comb begin
        costo = '0;
        for (int i = 0; i < NUM_PROG; i++) begin
            if (PROGRAMA_SEL == PSEL_W'(i)) costo = COSTOS[i*CNT_W +: CNT_W];
        end
    end

    always_ff @(posedge clk) begin
        if (RESET) begin
            state       <= ST_IDLE;
            moneda_prev <= 1'b0;
            credito_q   <= '0;
            cambio_q    <= '0;
            to_q        <= '0;
            oh_q        <= '0;
            cmode_q     <= 1'b0;
            insuf_q     <= 1'b0;
            ocup_q      <= 1'b0;
        end else begin
            state       <= state_n;
            moneda_prev <= INTRO_MONEDA;
            credito_q   <= credito_n;
            cambio_q    <= cambio_n;
            to_q        <= to_n;
            oh_q        <= oh_n;
            cmode_q     <= cmode_n;
            insuf_q     <= insuf_n;
            ocup_q      <= ocup_n;
        end
    end

    always_comb begin
        state_n   = state;
        credito_n = credito_q;
        cambio_n  = cambio_q;
        to_n      = to_q;
        oh_n      = oh_q;
        cmode_n   = cmode_q;
        insuf_n   = 1'b0;
        gen_load  = 1'b0;
        gen_count = '0;

        case (state)
            ST_IDLE: begin
                if (coin_edge) begin
                    credito_n = credito_inc;
                    to_n      = '0;
                    state_n   = ST_PAGO;
                end else if (FINALIZAR_PAGO) begin
                    insuf_n = 1'b1;
                end
            end
            ST_PAGO: begin
                if (coin_edge) begin
                    credito_n = credito_inc;
                    to_n      = '0;
                end else if (FINALIZAR_PAGO) begin
                    if (sel_invalid || (credito_q < costo)) begin
                        insuf_n = 1'b1;
                        to_n    = '0;
                    end else begin
                        oh_n      = NUM_PROG'(1) << PROGRAMA_SEL;
                        cmode_n   = 1'b0;
                        cambio_n  = credito_q - costo;
                        gen_load  = 1'b1;
                        gen_count = GEN_W'(N_PULSOS);
                        state_n   = ST_PULSO_ON;
                    end
                end else if (to_q == TO_W'(TIMEOUT - 1)) begin
                    // Full refund of the accumulated credit
                    oh_n      = '0;
                    cmode_n   = 1'b1;
                    cambio_n  = credito_q;
                    gen_load  = 1'b1;
                    gen_count = GEN_W'(credito_q);
                    state_n   = ST_CAMBIO_ON;
                end else begin
                    to_n = to_q + TO_W'(1);
                end
            end
            ST_PULSO_ON:  state_n = ST_PULSO_OFF;
            ST_PULSO_OFF: begin
                if (!gen_done) begin
                    state_n = ST_PULSO_ON;
                end else if (cambio_q != '0) begin
                    oh_n      = '0;
                    cmode_n   = 1'b1;
                    gen_load  = 1'b1;
                    gen_count = GEN_W'(cambio_q);
                    state_n   = ST_CAMBIO_ON;
                end else begin
                    oh_n      = '0;
                    credito_n = '0;
                    state_n   = ST_IDLE;
                end
            end
            ST_CAMBIO_ON: state_n = ST_CAMBIO_OFF;
            ST_CAMBIO_OFF: begin
                if (!gen_done) begin
                    state_n = ST_CAMBIO_ON;
                end else begin
                    cmode_n   = 1'b0;
                    cambio_n  = '0;
                    credito_n = '0;
                    state_n   = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase

        ocup_n = (state_n != ST_IDLE) && (state_n != ST_PAGO);
    end

    generador_pulsos #(.W(GEN_W)) u_gen (
        .clk    (clk),
        .reset  (RESET),
        .load   (gen_load),
        .count  (gen_count),
        .pulse  (gen_pulse),
        .done_c (gen_done)
    );

    // Single generator steered either to the selected program line or to the change line
    assign ACTIVAR      = oh_q & {NUM_PROG{gen_pulse}};
    assign CAMBIO       = gen_pulse && cmode_q;
    assign INSUFICIENTE = insuf_q;
    assign OCUPADO      = ocup_q;
    assign CREDITO      = credito_q;

endmodule

// File: tb/tb_lavadora_multiprograma.sv
// Directed bench for lavadora_multiprograma with a queue-based output model checked every cycle.
module tb_lavadora_multiprograma;

    logic       clk = 1'b0;
    logic       RESET = 1'b1;
    logic       INTRO_MONEDA = 1'b0;
    logic       FINALIZAR_PAGO = 1'b0;
    logic [1:0] PROGRAMA_SEL = 2'd0;
    logic [2:0] ACTIVAR;
    logic       INSUFICIENTE;
    logic       CAMBIO;
    logic       OCUPADO;
    logic [4:0] CREDITO;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    lavadora_multiprograma dut (
        .clk            (clk),
        .RESET          (RESET),
        .INTRO_MONEDA   (INTRO_MONEDA),
        .FINALIZAR_PAGO (FINALIZAR_PAGO),
        .PROGRAMA_SEL   (PROGRAMA_SEL),
        .ACTIVAR        (ACTIVAR),
        .INSUFICIENTE   (INSUFICIENTE),
        .CAMBIO         (CAMBIO),
        .OCUPADO        (OCUPADO),
        .CREDITO        (CREDITO)
    );

    // Model: expected outputs after each edge; an accepted purchase or refund is a precomputed output script
    typedef struct packed {
        logic [2:0] act;
        logic       cam;
        logic       ocu;
        logic [4:0] cred;
    } salida_t;

    localparam int N_PUL = 2;
    localparam int TOUT  = 64;
    int      costo [3] = '{3, 4, 9};
    salida_t seq [$];
    salida_t exp_o = '0;
    logic    exp_ins = 1'b0;
    logic    chk_en = 1'b0;
    logic    m_prev = 1'b0;
    logic    m_pago = 1'b0;
    int      m_credit = 0;
    int      m_idle = 0;
    logic    m_coin;

    task automatic build(input logic [2:0] oh, input int npul, input int change);
        for (int p = 0; p < npul; p++) begin
            seq.push_back('{act: oh, cam: 1'b0, ocu: 1'b1, cred: 5'(m_credit)});
            seq.push_back('{act: 3'b000, cam: 1'b0, ocu: 1'b1, cred: 5'(m_credit)});
        end
        for (int c = 0; c < change; c++) begin
            seq.push_back('{act: 3'b000, cam: 1'b1, ocu: 1'b1, cred: 5'(m_credit)});
            seq.push_back('{act: 3'b000, cam: 1'b0, ocu: 1'b1, cred: 5'(m_credit)});
        end
        seq.push_back('{act: 3'b000, cam: 1'b0, ocu: 1'b0, cred: 5'd0});
        m_credit = 0;
        m_pago   = 1'b0;
        m_idle   = 0;
    endtask

    always @(posedge clk) begin
        exp_ins = 1'b0;
        if (RESET) begin
            m_prev   = 1'b0;
            m_pago   = 1'b0;
            m_credit = 0;
            m_idle   = 0;
            seq.delete();
            exp_o    = '0;
            chk_en   = 1'b1;
        end else begin
            m_coin = INTRO_MONEDA && !m_prev;
            m_prev = INTRO_MONEDA;
            if (seq.size() == 0) begin
                if (m_coin) begin
                    if (m_credit < 31) m_credit++;
                    m_pago = 1'b1;
                    m_idle = 0;
                end else if (FINALIZAR_PAGO) begin
                    if (!m_pago) begin
                        exp_ins = 1'b1;
                    end else if (PROGRAMA_SEL > 2'd2) begin
                        exp_ins = 1'b1;
                        m_idle  = 0;
                    end else if (m_credit < costo[PROGRAMA_SEL]) begin
                        exp_ins = 1'b1;
                        m_idle  = 0;
                    end else begin
                        build(3'b001 << PROGRAMA_SEL, N_PUL, m_credit - costo[PROGRAMA_SEL]);
                    end
                end else if (m_pago) begin
                    m_idle++;
                    if (m_idle == TOUT) build(3'b000, 0, m_credit);
                end
            end
            if (seq.size() != 0) exp_o = seq.pop_front();
            else exp_o = '{act: 3'b000, cam: 1'b0, ocu: 1'b0, cred: 5'(m_credit)};
        end
    end

    task automatic cmp(input string nm, input int got, input int want);
        n_cmp++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, got, want);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            cmp("ACTIVAR", int'(ACTIVAR), int'(exp_o.act));
            cmp("CAMBIO", int'(CAMBIO), int'(exp_o.cam));
            cmp("OCUPADO", int'(OCUPADO), int'(exp_o.ocu));
            cmp("CREDITO", int'(CREDITO), int'(exp_o.cred));
            cmp("INSUFICIENTE", int'(INSUFICIENTE), int'(exp_ins));
        end
    end

    task automatic step(input logic m, input logic f, input logic [1:0] s);
        @(negedge clk);
        INTRO_MONEDA   = m;
        FINALIZAR_PAGO = f;
        PROGRAMA_SEL   = s;
    endtask

    task automatic coin(input int n);
        for (int i = 0; i < n; i++) begin
            step(1'b1, 1'b0, PROGRAMA_SEL);
            step(1'b0, 1'b0, PROGRAMA_SEL);
        end
    endtask

    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n_ocu;
        int n_cam;

        repeat (3) @(posedge clk);
        #1;
        cmp("lit_reset_credito", int'(CREDITO), 0);
        cmp("lit_reset_ocupado", int'(OCUPADO), 0);
        @(negedge clk);
        RESET = 1'b0;

        // 3 coins, secado: exact cost, two activation pulses, no change
        coin(3);
        cmp("lit_credit3", int'(CREDITO), 3);
        step(1'b0, 1'b1, 2'd0);
        after_edge();
        cmp("lit_sec_p1", int'(ACTIVAR), 1);
        FINALIZAR_PAGO = 1'b0;
        after_edge();
        cmp("lit_sec_gap", int'(ACTIVAR), 0);
        after_edge();
        cmp("lit_sec_p2", int'(ACTIVAR), 1);
        after_edge();
        cmp("lit_sec_end", int'(ACTIVAR), 0);
        after_edge();
        cmp("lit_sec_credito", int'(CREDITO), 0);
        cmp("lit_sec_idle", int'(OCUPADO), 0);

        // 6 coins, lavado: two activation pulses then two change pulses, coin while busy ignored
        coin(6);
        step(1'b0, 1'b1, 2'd1);
        n_ocu = 0;
        n_cam = 0;
        for (int i = 0; i < 12; i++) begin
            after_edge();
            FINALIZAR_PAGO = 1'b0;
            INTRO_MONEDA   = (i == 2);
            n_ocu += int'(OCUPADO);
            n_cam += int'(CAMBIO);
        end
        cmp("lit_lav_ocupado_cycles", n_ocu, 8);
        cmp("lit_lav_cambio_pulses", n_cam, 2);
        cmp("lit_lav_credito", int'(CREDITO), 0);

        // Insufficient credit for lavado pesado, then top up and buy
        coin(2);
        step(1'b0, 1'b1, 2'd2);
        after_edge();
        cmp("lit_insuf", int'(INSUFICIENTE), 1);
        cmp("lit_insuf_credito", int'(CREDITO), 2);
        FINALIZAR_PAGO = 1'b0;
        after_edge();
        cmp("lit_insuf_once", int'(INSUFICIENTE), 0);
        coin(7);
        cmp("lit_credit9", int'(CREDITO), 9);
        step(1'b0, 1'b1, 2'd2);
        after_edge();
        cmp("lit_pes_p1", int'(ACTIVAR), 4);
        FINALIZAR_PAGO = 1'b0;
        repeat (6) after_edge();

        // Level held high counts once; coin with finish credits and ignores finish; saturation
        step(1'b1, 1'b0, 2'd0);
        repeat (10) step(1'b1, 1'b0, 2'd0);
        step(1'b0, 1'b0, 2'd0);
        cmp("lit_held_credit", int'(CREDITO), 1);
        step(1'b1, 1'b1, 2'd0);
        after_edge();
        cmp("lit_coinfin_credit", int'(CREDITO), 2);
        cmp("lit_coinfin_noinsuf", int'(INSUFICIENTE), 0);
        step(1'b0, 1'b0, 2'd0);
        coin(38);
        cmp("lit_saturate", int'(CREDITO), 31);
        repeat (64 + 62 + 10) after_edge();
        cmp("lit_refund31_idle", int'(OCUPADO), 0);

        // Timeout refund of 2 coins after 64 idle edges
        coin(1);
        step(1'b1, 1'b0, 2'd0);
        after_edge();
        INTRO_MONEDA = 1'b0;
        repeat (63) @(posedge clk);
        #1;
        cmp("lit_to_before", int'(CAMBIO), 0);
        after_edge();
        cmp("lit_to_fire", int'(CAMBIO), 1);
        repeat (6) after_edge();
        cmp("lit_to_idle", int'(OCUPADO), 0);

        // Out-of-range select
        coin(1);
        step(1'b0, 1'b1, 2'd3);
        after_edge();
        cmp("lit_sel3_insuf", int'(INSUFICIENTE), 1);
        FINALIZAR_PAGO = 1'b0;
        repeat (72) after_edge();

        // Reset during the second activation pulse
        PROGRAMA_SEL = 2'd0;
        coin(3);
        step(1'b0, 1'b1, 2'd0);
        after_edge();
        FINALIZAR_PAGO = 1'b0;
        INTRO_MONEDA   = 1'b1;
        after_edge();
        INTRO_MONEDA   = 1'b0;
        after_edge();
        cmp("lit_rst_second_pulse", int'(ACTIVAR), 1);
        RESET = 1'b1;
        after_edge();
        cmp("lit_rst_activar", int'(ACTIVAR), 0);
        cmp("lit_rst_credito", int'(CREDITO), 0);
        cmp("lit_rst_ocupado", int'(OCUPADO), 0);
        RESET = 1'b0;
        repeat (4) after_edge();
        cmp("lit_rst_after", int'(CREDITO), 0);

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
